// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op codes, FSM state encoding and the default datapath width.
package muldiv_pkg;

    localparam int DATA_WIDTH = 64;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULH = 3'b001;
    localparam logic [2:0] OP_UDIV  = 3'b010;
    localparam logic [2:0] OP_SMULH = 3'b011;
    localparam logic [2:0] OP_SDIV  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the
// multiply/divide unit (slave).
interface ex_muldiv_unit_if #(
    parameter int DATA_WIDTH = muldiv_pkg::DATA_WIDTH
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] operandA;
    logic [DATA_WIDTH-1:0] operandB;
    logic                  flush;
    logic                  stall;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic                  divByZero;
    logic                  illegalOp;

    modport master (
        output start, op, operandA, operandB, flush,
        input  stall, done, result, divByZero, illegalOp
    );

    modport slave (
        input  start, op, operandA, operandB, flush,
        output stall, done, result, divByZero, illegalOp
    );
endinterface

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Conditional two's-complement negate. Used to take operand magnitudes and
// to restore the sign of the unsigned core's result.
module muldiv_sign_fix #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);
    // Negate when requested, pass through otherwise.
    always_comb begin
        o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit for the EX stage.
// Multiplies use shift-add into a 2*W accumulator; divides use restoring
// division with the quotient shifting into the low half of the same
// accumulator and the remainder in the high half.
// Optional feature macro: SIGNED_MULDIV_EN enables SMULH and SDIV.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = muldiv_pkg::DATA_WIDTH
) (
    input  logic              CLOCK,
    input  logic              RESET,
    ex_muldiv_unit_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    state_t           r_state;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_a;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_take_hi;
    logic [W-1:0]     r_result;
    logic             r_done;
    logic             r_dz;
    logic             r_il;

    logic             w_accept;
    logic             w_legal;
    logic             w_div;
    logic             w_hi;
    logic [W-1:0]     w_mag_a;
    logic [W-1:0]     w_mag_b;
    logic [W:0]       w_sum;
    logic [2*W-1:0]   w_mul_nxt;
    logic [W:0]       w_rem_sh;
    logic [W:0]       w_trial;
    logic             w_ge;
    logic [2*W-1:0]   w_div_nxt;
    logic [2*W-1:0]   w_acc_nxt;
    logic [2*W-1:0]   w_fin;
    logic [W-1:0]     w_res_val;

    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.flush;

`ifdef SIGNED_MULDIV_EN
    logic             w_signed_op;
    logic             w_neg_res;
    logic             r_neg;

    assign w_signed_op = (bus.op == OP_SMULH) || (bus.op == OP_SDIV);
    assign w_neg_res   = w_signed_op && (bus.operandA[W-1] ^ bus.operandB[W-1]);
    assign w_legal     = (bus.op == OP_MUL) || (bus.op == OP_UMULH) ||
                         (bus.op == OP_UDIV) || w_signed_op;
    assign w_div       = (bus.op == OP_UDIV) || (bus.op == OP_SDIV);
    assign w_hi        = (bus.op == OP_UMULH) || (bus.op == OP_SMULH);

    muldiv_sign_fix #(.WIDTH(W)) u_fix_a (
        .i_val (bus.operandA),
        .i_neg (w_signed_op && bus.operandA[W-1]),
        .o_val (w_mag_a)
    );
    muldiv_sign_fix #(.WIDTH(W)) u_fix_b (
        .i_val (bus.operandB),
        .i_neg (w_signed_op && bus.operandB[W-1]),
        .o_val (w_mag_b)
    );
    // Negating the full 2W value gives the SMULH high half directly and,
    // since the low half of a negation depends only on low bits, the SDIV
    // quotient in the low half even with the remainder sitting above it.
    muldiv_sign_fix #(.WIDTH(2*W)) u_fix_res (
        .i_val (w_acc_nxt),
        .i_neg (r_neg),
        .o_val (w_fin)
    );

    // Result sign is captured once, when the op is accepted.
    always_ff @(posedge CLOCK) begin
        if (RESET)
            r_neg <= 1'b0;
        else if (w_accept)
            r_neg <= w_neg_res;
    end
`else
    assign w_legal = (bus.op == OP_MUL) || (bus.op == OP_UMULH) || (bus.op == OP_UDIV);
    assign w_div   = (bus.op == OP_UDIV);
    assign w_hi    = (bus.op == OP_UMULH);
    assign w_mag_a = bus.operandA;
    assign w_mag_b = bus.operandB;
    assign w_fin   = w_acc_nxt;
`endif

    // One iteration of the datapath for both multiply and divide.
    always_comb begin
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit (acc[0]) is set, then shift the whole thing right.
        w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
        w_mul_nxt = {w_sum, r_acc[W-1:1]};
        // Restoring divide: bring the next dividend bit into the remainder,
        // keep the subtraction only if it did not go negative.
        w_rem_sh  = {r_acc[2*W-1:W], r_acc[W-1]};
        w_trial   = w_rem_sh - {1'b0, r_b};
        w_ge      = !w_trial[W];
        w_div_nxt = {(w_ge ? w_trial[W-1:0] : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};
        w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
        w_res_val = r_take_hi ? w_fin[2*W-1:W] : w_fin[W-1:0];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_il      <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_is_div  <= 1'b0;
            r_take_hi <= 1'b0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_il    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_cnt     <= '0;
                        r_dz      <= 1'b0;
                        r_il      <= 1'b0;
                        r_a       <= w_mag_a;
                        r_b       <= w_mag_b;
                        r_is_div  <= w_div;
                        r_take_hi <= w_hi;
                        r_acc     <= w_div ? {{W{1'b0}}, w_mag_a} : {{W{1'b0}}, w_mag_b};
                        if (!w_legal) begin
                            r_result <= '0;
                            r_il     <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else if (w_div && (bus.operandB == '0)) begin
                            r_result <= '0;
                            r_dz     <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W-1)) begin
                        r_result <= w_res_val;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall covers the accept cycle and every iteration; it drops in DONE
    // so the pipeline captures the result alongside the ALU result.
    assign bus.stall     = !RESET && (w_accept || (r_state == ST_RUN));
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.divByZero = r_dz;
    assign bus.illegalOp = r_il;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
// Build with +define+SIGNED_MULDIV_EN to cover the signed ops.
module tb_ex_muldiv_unit;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

    ex_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it to done. poke>0 pulses start with other
    // operands at that cycle offset to show it is ignored mid-run.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input int exp_lat, input logic [63:0] exp_res,
                          input logic exp_dz, input logic exp_il, input int poke);
        int lat;
        int stall_lo;
        @(negedge clk);
        bus.op = op; bus.operandA = a; bus.operandB = b; bus.start = 1'b1;
        #1 chk({tag, " stallN"}, {63'd0, bus.stall}, 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        stall_lo = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.stall !== 1'b1) stall_lo++;
            @(negedge clk);
            lat++;
            if (lat == poke) begin
                bus.start = 1'b1; bus.op = 3'b000;
                bus.operandA = 64'd11; bus.operandB = 64'd13;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        #1;
        chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, " stall_run"}, 64'(stall_lo), 64'd0);
        chk({tag, " stall_done"}, {63'd0, bus.stall}, 64'd0);
        chk({tag, " result"}, bus.result, exp_res);
        chk({tag, " dz"}, {63'd0, bus.divByZero}, {63'd0, exp_dz});
        chk({tag, " il"}, {63'd0, bus.illegalOp}, {63'd0, exp_il});
        @(negedge clk);
        #1 chk({tag, " done1"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int ndone;
        bus.start = 1'b1; bus.op = 3'b000; bus.operandA = 64'd7; bus.operandB = 64'd6;
        bus.flush = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst stall", {63'd0, bus.stall}, 64'd0);
            chk("rst done", {63'd0, bus.done}, 64'd0);
            chk("rst result", bus.result, 64'd0);
        end
        bus.start = 1'b0;
        rst = 1'b0;

        run_op("mul7x6", 3'b000, 64'd7, 64'd6, 65, 64'd42, 1'b0, 1'b0, 0);
        run_op("umulh", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'd1, 1'b0, 1'b0, 0);
        run_op("mulmax", 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op("udiv", 3'b010, 64'd100, 64'd7, 65, 64'd14, 1'b0, 1'b0, 0);

        // Flush at RUN iteration 10: no done, result keeps 14.
        @(negedge clk);
        bus.op = 3'b000; bus.operandA = 64'd5; bus.operandB = 64'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1 chk("flush stall_run", {63'd0, bus.stall}, 64'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1 chk("flush idle", {63'd0, bus.stall}, 64'd0);
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("flush nodone", 64'(ndone), 64'd0);
        chk("flush result", bus.result, 64'd14);

        run_op("mul3x3", 3'b000, 64'd3, 64'd3, 65, 64'd9, 1'b0, 1'b0, 20);
        run_op("udiv0", 3'b010, 64'd5, 64'd0, 1, 64'd0, 1'b1, 1'b0, 0);

        // Flush in IDLE clears held flags but keeps the result.
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1 chk("flush dzclr", {63'd0, bus.divByZero}, 64'd0);

`ifdef SIGNED_MULDIV_EN
        run_op("sdiv", 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65,
               64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 1'b0, 0);
        run_op("smulh", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0);
        run_op("sdivmin", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65,
               64'h8000_0000_0000_0000, 1'b0, 1'b0, 0);
`else
        run_op("sdiv_ill", 3'b100, 64'd100, 64'd7, 1, 64'd0, 1'b0, 1'b1, 0);
        run_op("smulh_ill", 3'b011, 64'd3, 64'd4, 1, 64'd0, 1'b0, 1'b1, 0);
`endif
        run_op("mul_pre", 3'b000, 64'd4, 64'd5, 65, 64'd20, 1'b0, 1'b0, 0);
        run_op("op7_ill", 3'b111, 64'd4, 64'd5, 1, 64'd0, 1'b0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
